// File: rtl/cache_refill_engine_pkg.sv
// Shared definitions for the cache refill engine.
//   refill_state_e : refill FSM encoding
//   miss_src_e     : which pipe raised the miss
//   line_addr()    : clears the line-offset bits of a byte address
//   word_idx()     : extracts the word index within the line
// The helpers take the data width and line size as arguments so one package
// serves every parameterisation of the engine.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } refill_state_e;

    typedef enum logic {
        SRC_DPIPE = 1'b0,
        SRC_IPIPE = 1'b1
    } miss_src_e;

    function automatic logic [63:0] line_addr(input logic [63:0] addr,
                                              input int data_width,
                                              input int line_words);
        int off_bits;
        off_bits = $clog2(data_width / 8) + $clog2(line_words);
        return addr & ~((64'd1 << off_bits) - 64'd1);
    endfunction

    function automatic int word_idx(input logic [63:0] addr,
                                    input int data_width,
                                    input int line_words);
        logic [63:0] w;
        w = (addr >> $clog2(data_width / 8)) & 64'(line_words - 1);
        return int'(w);
    endfunction

endpackage

// File: rtl/cache_refill_engine.sv
// Line-fill engine: takes one miss at a time, issues a single burst read for
// the line, writes each returned beat into the data array, forwards the
// critical word as soon as it is written and finally sets the tag.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   miss_*               : miss request from the cache controller (vld/rdy)
//   mem_req_*            : burst read request to memory (vld/rdy)
//   mem_rsp_*            : returned beats; always accepted while filling
//   fill_*               : registered data-array write port
//   tag_we_o             : tag/valid write for fill_addr_o
//   crit_*               : critical-word forward pulse
//   done_*               : completion pulse with error and requester
module cache_refill_engine
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          miss_vld_i,
    output logic                          miss_rdy_o,
    input  logic [ADDR_WIDTH-1:0]         miss_addr_i,
    input  logic                          miss_src_i,
    output logic                          mem_req_vld_o,
    input  logic                          mem_req_rdy_i,
    output logic [ADDR_WIDTH-1:0]         mem_req_addr_o,
    output logic [$clog2(LINE_WORDS)-1:0] mem_req_len_o,
    input  logic                          mem_rsp_vld_i,
    output logic                          mem_rsp_rdy_o,
    input  logic [DATA_WIDTH-1:0]         mem_rsp_data_i,
    input  logic                          mem_rsp_err_i,
    input  logic                          mem_rsp_last_i,
    output logic                          fill_we_o,
    output logic [ADDR_WIDTH-1:0]         fill_addr_o,
    output logic [$clog2(LINE_WORDS)-1:0] fill_word_o,
    output logic [DATA_WIDTH-1:0]         fill_data_o,
    output logic                          tag_we_o,
    output logic                          crit_vld_o,
    output logic [DATA_WIDTH-1:0]         crit_data_o,
    output logic                          done_vld_o,
    output logic                          done_err_o,
    output logic                          done_src_o
);

    localparam int IDX_W = $clog2(LINE_WORDS);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_REQ  = REQ;
    localparam logic [1:0] ST_FILL = FILL;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]            state_q;
    logic [ADDR_WIDTH-1:0] line_q;
    logic [IDX_W-1:0]      crit_q;
    logic [IDX_W-1:0]      cnt_q;
    logic                  src_q;
    logic                  err_q;

    logic in_idle, in_req, in_fill, in_done;
    logic accept, beat, last_idx, beat_err, err_next;

    assign in_idle = (state_q == ST_IDLE);
    assign in_req  = (state_q == ST_REQ);
    assign in_fill = (state_q == ST_FILL);
    assign in_done = (state_q == ST_DONE);

    // Held low while reset is asserted so a miss is never taken in that cycle.
    assign miss_rdy_o = in_idle & ~reset;
    assign accept     = miss_vld_i & miss_rdy_o;
    assign beat       = in_fill & mem_rsp_vld_i;
    assign last_idx   = (cnt_q == IDX_W'(LINE_WORDS - 1));
    // A last marker on the wrong beat (or missing on the final one) poisons
    // the line just like a bus error.
    assign beat_err   = mem_rsp_err_i | (mem_rsp_last_i != last_idx);
    // Includes the current beat, so an erring beat suppresses its own write.
    assign err_next   = err_q | (beat & beat_err);

    assign mem_req_vld_o  = in_req;
    assign mem_req_addr_o = line_q;
    assign mem_req_len_o  = IDX_W'(LINE_WORDS - 1);
    assign mem_rsp_rdy_o  = in_fill;
    assign fill_addr_o    = line_q;

    // DONE coincides with the registered write of the final beat.
    assign done_vld_o = in_done;
    assign done_err_o = in_done & err_q;
    assign done_src_o = in_done & src_q;
    assign tag_we_o   = in_done & ~err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            line_q      <= '0;
            crit_q      <= '0;
            cnt_q       <= '0;
            src_q       <= 1'(SRC_DPIPE);
            err_q       <= 1'b0;
            fill_we_o   <= 1'b0;
            fill_word_o <= '0;
            fill_data_o <= '0;
            crit_vld_o  <= 1'b0;
            crit_data_o <= '0;
        end else begin
            fill_we_o  <= beat & ~err_next;
            crit_vld_o <= beat & ~err_next & (cnt_q == crit_q);
            if (beat) begin
                fill_word_o <= cnt_q;
                fill_data_o <= mem_rsp_data_i;
            end
            if (beat & ~err_next & (cnt_q == crit_q))
                crit_data_o <= mem_rsp_data_i;

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        line_q  <= ADDR_WIDTH'(line_addr(64'(miss_addr_i), DATA_WIDTH, LINE_WORDS));
                        crit_q  <= IDX_W'(word_idx(64'(miss_addr_i), DATA_WIDTH, LINE_WORDS));
                        src_q   <= miss_src_i;
                        err_q   <= 1'b0;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_req_rdy_i) begin
                        cnt_q   <= '0;
                        state_q <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (beat) begin
                        cnt_q <= cnt_q + 1'b1;
                        err_q <= err_next;
                        // The beat count, not the last marker, ends the burst
                        // so a misbehaving memory is always fully drained.
                        if (last_idx)
                            state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_engine.sv
// Self-checking bench for cache_refill_engine (default parameters).
// A table of miss scenarios is run through one driver task; expected fill
// writes and critical words are queued as beats are driven and popped as the
// DUT produces them. Chained misses and a mid-fill reset are hand sequences.
module tb_cache_refill_engine;

    typedef struct {
        logic [31:0] addr;
        logic        src;
        int          err_beat;   // beat carrying mem_rsp_err_i, -1 for none
        int          last_beat;  // beat carrying mem_rsp_last_i
        int          stall;      // cycles mem_req_rdy_i is held low
        int          gap;        // idle cycles between beats
        logic [31:0] exp_line;
        int          exp_crit;
        logic        exp_err;
        int          exp_lat;    // accept-to-done cycles, -1 to skip
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        miss_vld_i = 1'b0;
    logic        miss_rdy_o;
    logic [31:0] miss_addr_i = '0;
    logic        miss_src_i = 1'b0;
    logic        mem_req_vld_o;
    logic        mem_req_rdy_i = 1'b0;
    logic [31:0] mem_req_addr_o;
    logic [1:0]  mem_req_len_o;
    logic        mem_rsp_vld_i = 1'b0;
    logic        mem_rsp_rdy_o;
    logic [31:0] mem_rsp_data_i = '0;
    logic        mem_rsp_err_i = 1'b0;
    logic        mem_rsp_last_i = 1'b0;
    logic        fill_we_o;
    logic [31:0] fill_addr_o;
    logic [1:0]  fill_word_o;
    logic [31:0] fill_data_o;
    logic        tag_we_o;
    logic        crit_vld_o;
    logic [31:0] crit_data_o;
    logic        done_vld_o;
    logic        done_err_o;
    logic        done_src_o;

    always #5 clk = ~clk;

    cache_refill_engine dut (
        .clk(clk), .reset(reset),
        .miss_vld_i(miss_vld_i), .miss_rdy_o(miss_rdy_o),
        .miss_addr_i(miss_addr_i), .miss_src_i(miss_src_i),
        .mem_req_vld_o(mem_req_vld_o), .mem_req_rdy_i(mem_req_rdy_i),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_len_o(mem_req_len_o),
        .mem_rsp_vld_i(mem_rsp_vld_i), .mem_rsp_rdy_o(mem_rsp_rdy_o),
        .mem_rsp_data_i(mem_rsp_data_i), .mem_rsp_err_i(mem_rsp_err_i),
        .mem_rsp_last_i(mem_rsp_last_i),
        .fill_we_o(fill_we_o), .fill_addr_o(fill_addr_o),
        .fill_word_o(fill_word_o), .fill_data_o(fill_data_o),
        .tag_we_o(tag_we_o), .crit_vld_o(crit_vld_o), .crit_data_o(crit_data_o),
        .done_vld_o(done_vld_o), .done_err_o(done_err_o), .done_src_o(done_src_o)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_seen = 0;
    int tx_n = 0;
    int last_done_cyc = 0;
    logic [31:0] cur_line = '0;
    logic [33:0] exp_fill_q[$];
    logic [33:0] exp_crit_q[$];
    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to the next falling edge and score whatever the DUT emitted.
    task automatic tick();
        logic [33:0] e;
        @(negedge clk);
        cyc++;
        if (fill_we_o) begin
            if (exp_fill_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL fill_unexpected: got write word %0d data %0h, required none",
                         fill_word_o, fill_data_o);
            end else begin
                e = exp_fill_q.pop_front();
                chk("fill_word_data", {30'd0, fill_word_o, fill_data_o}, {30'd0, e});
                chk("fill_addr", fill_addr_o, cur_line);
            end
        end
        if (crit_vld_o) begin
            if (exp_crit_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL crit_unexpected: got crit data %0h, required none", crit_data_o);
            end else begin
                e = exp_crit_q.pop_front();
                chk("crit_word_data", {30'd0, fill_word_o, crit_data_o}, {30'd0, e});
                chk("crit_with_fill", fill_we_o, 1);
            end
        end
        if (done_vld_o) done_seen++;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctrl"}, {miss_rdy_o, mem_req_vld_o, mem_rsp_rdy_o, fill_we_o, fill_word_o,
                             tag_we_o, crit_vld_o, done_vld_o, done_err_o, done_src_o}, 0);
        chk({tag, "_addr"}, {mem_req_addr_o, fill_addr_o}, 0);
        chk({tag, "_data"}, {fill_data_o, crit_data_o}, 0);
    endtask

    // One complete miss. keep leaves miss_vld_i high afterwards; chained checks
    // acceptance exactly one cycle after the previous done; abort >= 0 asserts
    // reset instead of driving that beat.
    task automatic run_miss(input vec_t v, input logic [31:0] base, input bit keep,
                            input bit chained, input int abort);
        int c0, n, vldc;
        bit e_run, bad;
        miss_vld_i  = 1'b1;
        miss_addr_i = v.addr;
        miss_src_i  = v.src;
        n = 0;
        while (!miss_rdy_o && n < 20) begin tick(); n++; end
        if (!miss_rdy_o) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got miss_rdy_o 0 for 20 cycles, required 1");
            miss_vld_i = 1'b0;
            return;
        end
        c0 = cyc;
        if (chained) chk("accept_after_done", c0 - last_done_cyc, 1);
        cur_line = v.exp_line;
        tick();
        if (!keep) miss_vld_i = 1'b0;

        vldc = 0;
        for (int s = 0; s <= v.stall; s++) begin
            if (mem_req_vld_o) vldc++;
            chk("req_addr", mem_req_addr_o, v.exp_line);
            chk("miss_rdy_req", miss_rdy_o, 0);
            mem_req_rdy_i = (s == v.stall);
            tick();
        end
        mem_req_rdy_i = 1'b0;
        chk("req_vld_cycles", vldc, v.stall + 1);
        chk("req_len", mem_req_len_o, 3);

        e_run = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == abort) begin
                reset = 1'b1;
                mem_rsp_vld_i = 1'b0;
                tick();
                check_zero("mid_reset");
                reset = 1'b0;
                exp_fill_q.delete();
                exp_crit_q.delete();
                tick();
                chk("idle_after_reset", miss_rdy_o, 1);
                return;
            end
            if (k > 0) begin
                for (int g = 0; g < v.gap; g++) begin
                    mem_rsp_vld_i = 1'b0;
                    chk("miss_rdy_gap", miss_rdy_o, 0);
                    tick();
                end
            end
            bad = (k == v.err_beat) || ((k == v.last_beat) != (k == 3));
            e_run = e_run | bad;
            mem_rsp_vld_i  = 1'b1;
            mem_rsp_data_i = base + 32'(k);
            mem_rsp_err_i  = (k == v.err_beat);
            mem_rsp_last_i = (k == v.last_beat);
            if (!e_run) begin
                exp_fill_q.push_back({2'(k), base + 32'(k)});
                if (k == v.exp_crit) exp_crit_q.push_back({2'(k), base + 32'(k)});
            end
            chk("rsp_rdy", mem_rsp_rdy_o, 1);
            chk("miss_rdy_fill", miss_rdy_o, 0);
            tick();
        end
        mem_rsp_vld_i  = 1'b0;
        mem_rsp_err_i  = 1'b0;
        mem_rsp_last_i = 1'b0;

        tx_n++;
        chk("done_vld", done_vld_o, 1);
        chk("done_err", done_err_o, v.exp_err);
        chk("done_src", done_src_o, v.src);
        chk("tag_we", tag_we_o, !v.exp_err);
        if (v.exp_lat >= 0) chk("latency", cyc - c0, v.exp_lat);
        last_done_cyc = cyc;
        tick();
        chk("done_pulse_width", {done_vld_o, tag_we_o}, 0);
        chk("fill_q_drained", exp_fill_q.size(), 0);
        chk("crit_q_drained", exp_crit_q.size(), 0);
        chk("done_count", done_seen, tx_n);
    endtask

    initial begin
        vec_t v;
        //            addr           src   err last stall gap line           crit err  lat
        vecs[0] = '{32'h0000_1238, 1'b1, -1, 3, 0, 0, 32'h0000_1230, 2, 1'b0, 6};
        vecs[1] = '{32'h0000_2004, 1'b0, -1, 3, 5, 1, 32'h0000_2000, 1, 1'b0, -1};
        vecs[2] = '{32'h0000_1238, 1'b1,  1, 3, 0, 0, 32'h0000_1230, 2, 1'b1, 6};
        vecs[3] = '{32'h0000_300C, 1'b0, -1, 2, 0, 0, 32'h0000_3000, 3, 1'b1, 6};
        vecs[4] = '{32'hFFFF_FFF4, 1'b1, -1, 3, 1, 2, 32'hFFFF_FFF0, 1, 1'b0, -1};
        vecs[5] = '{32'h0000_00AC, 1'b0,  3, 3, 0, 0, 32'h0000_00A0, 3, 1'b1, 6};
        vecs[6] = '{32'h0000_5001, 1'b1,  0, 3, 2, 0, 32'h0000_5000, 0, 1'b1, -1};

        tick();
        tick();
        check_zero("reset");
        reset = 1'b0;
        tick();
        chk("rdy_after_reset", miss_rdy_o, 1);

        for (int i = 0; i < 7; i++)
            run_miss(vecs[i], 32'h0000_00A0 + 32'(i << 8), 1'b0, 1'b0, -1);

        // miss_vld_i held high across two back-to-back fills
        v = '{32'h0000_0040, 1'b0, -1, 3, 0, 0, 32'h0000_0040, 0, 1'b0, 6};
        run_miss(v, 32'h0000_1100, 1'b1, 1'b0, -1);
        v = '{32'h0000_0088, 1'b1, -1, 3, 0, 0, 32'h0000_0080, 2, 1'b0, 6};
        run_miss(v, 32'h0000_2200, 1'b0, 1'b1, -1);

        // reset after two beats (the second erring), then a clean fill
        v = '{32'h0000_6008, 1'b1, 1, 3, 0, 0, 32'h0000_6000, 2, 1'b1, -1};
        run_miss(v, 32'h0000_3300, 1'b0, 1'b0, 2);
        v = '{32'h0000_7004, 1'b1, -1, 3, 0, 0, 32'h0000_7000, 1, 1'b0, 6};
        run_miss(v, 32'h0000_4400, 1'b0, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_refill_engine.md
Name: cache_refill_engine

Overview:
- Services line-fill requests from the cache controller FSM after a D- or I-pipe miss.
- Issues one burst read to the memory side, writes the returned beats into the cache data array and the tag entry, and forwards the critical word early.
- Signals completion back to the controller.
- Handles one miss at a time.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data beat / cache word width in bits (power of 2, >=8)
LINE_WORDS, 4, words per cache line (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
miss_vld_i  in  1  miss request valid
miss_rdy_o  out  1  engine ready to accept a miss
miss_addr_i  in  ADDR_WIDTH  byte address of the missing access
miss_src_i  in  1  requester: 0 = dpipe, 1 = ipipe
mem_req_vld_o  out  1  burst read request valid
mem_req_rdy_i  in  1  memory accepts request
mem_req_addr_o  out  ADDR_WIDTH  line-aligned burst address
mem_req_len_o  out  $clog2(LINE_WORDS)  beats minus one, constant LINE_WORDS-1
mem_rsp_vld_i  in  1  response beat valid
mem_rsp_rdy_o  out  1  engine accepts beat
mem_rsp_data_i  in  DATA_WIDTH  beat data
mem_rsp_err_i  in  1  beat error
mem_rsp_last_i  in  1  final beat marker
fill_we_o  out  1  data array write enable
fill_addr_o  out  ADDR_WIDTH  line-aligned address of the line being filled
fill_word_o  out  $clog2(LINE_WORDS)  word index within the line
fill_data_o  out  DATA_WIDTH  write data
tag_we_o  out  1  tag/valid write enable for fill_addr_o
crit_vld_o  out  1  critical word valid (1-cycle pulse)
crit_data_o  out  DATA_WIDTH  critical word
done_vld_o  out  1  fill complete (1-cycle pulse)
done_err_o  out  1  fill failed; qualified by done_vld_o
done_src_o  out  1  miss_src_i latched for this fill; qualified by done_vld_o

Behaviour:
- Address split:
  - OFF_BITS = $clog2(DATA_WIDTH/8) + $clog2(LINE_WORDS).
  - Line address = miss_addr_i with the low OFF_BITS bits cleared.
  - Critical index = miss_addr_i[OFF_BITS-1 : $clog2(DATA_WIDTH/8)].
- States: IDLE, REQ, FILL, DONE. Reset -> IDLE.
- Reset values:
  - All valid/enable outputs = 0, miss_rdy_o = 0 in the reset cycle.
  - All data/address outputs = 0.
  - Beat counter = 0, error flag = 0.
- IDLE:
  - miss_rdy_o = 1.
  - On miss_vld_i & miss_rdy_o: latch line address, critical index and src; clear the error flag; go to REQ.
- REQ:
  - mem_req_vld_o = 1 with stable addr/len until mem_req_rdy_i.
  - On handshake -> FILL, beat counter = 0.
- FILL:
  - mem_rsp_rdy_o = 1.
  - Each accepted beat increments the counter.
  - Error flag |= mem_rsp_err_i.
  - Error flag |= (mem_rsp_last_i != (counter == LINE_WORDS-1)).
  - Fill output is registered: the cycle after an accepted beat, fill_we_o = 1 with fill_word_o = counter value at acceptance and fill_data_o = beat data. fill_we_o is suppressed if the error flag is set, including by that beat.
  - When the beat index equals the critical index and that beat is error-free, crit_vld_o/crit_data_o pulse in the same registered cycle as its fill write.
  - Acceptance of beat LINE_WORDS-1 -> DONE, regardless of mem_rsp_last_i.
- DONE, exactly one cycle, concurrent with the final fill write:
  - done_vld_o = 1; done_err_o = error flag; done_src_o = latched src.
  - tag_we_o = !error flag.
  - Next state IDLE.
- Error rules:
  - Once any beat errs, all remaining beats are still drained.
  - Earlier successful writes stand; the tag is never written, so the line stays invalid.
- miss_rdy_o = 0 outside IDLE; a new miss is accepted at the earliest 1 cycle after DONE.
- Minimum latency with memory always ready and beats back-to-back:
  - Accept T; request T+1.
  - Beats T+2..T+1+LINE_WORDS.
  - done_vld_o at T+2+LINE_WORDS.
- Back-pressure: mem_rsp_rdy_o is always 1 in FILL. Bubbles (mem_rsp_vld_i = 0) stall the counter without effect.
- Reset mid-operation: immediate return to IDLE, all pulses dropped, no tag write. The memory side shares the same reset and discards any outstanding burst.

Decomposition:
- Package cache_pkg:
  - refill_state_e (IDLE, REQ, FILL, DONE).
  - miss_src_e (SRC_DPIPE = 0, SRC_IPIPE = 1).
  - Functions line_addr() and word_idx() parameterised by DATA_WIDTH/LINE_WORDS.
- No sub-module: a single FSM plus a counter fits in one module.

Test Plan:
1. Defaults, miss_addr_i = 0x0000_1238, src = 1, memory always ready, data 0xA0..0xA3 -> mem_req_addr_o = 0x1230, len = 3; fill writes words 0..3; crit_vld_o with 0xA2 alongside word 2; tag_we_o, done_vld_o, done_src_o = 1, done_err_o = 0 at T+6.
2. mem_req_rdy_i held low 5 cycles, then beats with one idle cycle between each -> mem_req_vld_o stable 6 cycles; exactly 4 fill writes; done_vld_o one cycle after beat 3.
3. Beat 1 with mem_rsp_err_i = 1 -> only word 0 written; no crit_vld_o for critical index 2; beats 2..3 drained; tag_we_o = 0; done_err_o = 1.
4. mem_rsp_last_i asserted on beat 2 -> done_err_o = 1, no tag write; engine still consumes beat 3 before DONE.
5. miss_vld_i held high across two fills (0x40 then 0x80) -> second accepted only in the cycle after the first done_vld_o; miss_rdy_o = 0 throughout FILL.
6. reset asserted mid-FILL after 2 beats -> the next cycle all outputs are 0 and state is IDLE; a fresh miss completes normally with no stale counter or error state.
